csr_file: RTL and testbench

//  Parametrised host-visible control/status register file for TSIM accelerators.

---
 rtl/csr_pkg.sv | 31 +++
 rtl/csr_file_if.sv | 26 ++
 rtl/csr_event_counter.sv | 24 ++
 rtl/csr_file.sv | 137 +++++++++++++
 tb/tb_csr_file.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_pkg.sv
// Shared types and helpers for the host CSR file.
package csr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    localparam int CTRL_LAUNCH = 0;
    localparam int CTRL_FINISH = 1;
    localparam int CTRL_BUSY   = 2;

    // Decoded register select: idx 0 = CTRL, 1..NE = EVT, NE+1.. = ARG.
    typedef struct packed {
        logic        valid;
        logic [15:0] idx;
    } reg_sel_t;

    // Word index of a byte address; invalid when misaligned or past the map.
    function automatic reg_sel_t reg_index(input logic [31:0] addr,
                                           input int unsigned num_regs);
        reg_sel_t s;
        s.idx   = addr[17:2];
        s.valid = (addr[1:0] == 2'b00) && ((addr >> 2) < num_regs);
        return s;
    endfunction

endpackage

// File: rtl/csr_file_if.sv
// Host request/response port of the CSR file.
interface csr_file_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 32
);
    logic                 host_req_valid;
    logic                 host_req_opcode;
    logic [ADDR_BITS-1:0] host_req_addr;
    logic [DATA_BITS-1:0] host_req_value;
    logic                 host_req_deq;
    logic                 host_resp_valid;
    logic                 host_resp_ready;
    logic [DATA_BITS-1:0] host_resp_bits;

    modport master (
        output host_req_valid, host_req_opcode, host_req_addr, host_req_value,
        output host_resp_ready,
        input  host_req_deq, host_resp_valid, host_resp_bits
    );

    modport slave (
        input  host_req_valid, host_req_opcode, host_req_addr, host_req_value,
        input  host_resp_ready,
        output host_req_deq, host_resp_valid, host_resp_bits
    );
endinterface

// File: rtl/csr_event_counter.sv
// Saturating event counter with synchronous clear (clear wins over increment).
module csr_event_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_clear,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);
    logic [W-1:0] r_count;

    // Count up, holding at all-ones instead of wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_count <= '0;
        else if (i_clear)
            r_count <= '0;
        else if (i_inc && (r_count != {W{1'b1}}))
            r_count <= r_count + W'(1);
    end

    assign o_count = r_count;
endmodule

// File: rtl/csr_file.sv
// Host-visible CSR file: CTRL launch/finish handshake, event counters, args.
module csr_file
    import csr_pkg::*;
#(
    parameter int HOST_ADDR_BITS = 8,
    parameter int HOST_DATA_BITS = 32,
    parameter int NUM_EVENTS     = 2,
    parameter int NUM_ARGS       = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    csr_file_if.slave                          host,
    output logic                               launch,
    input  logic                               finish,
    input  logic [NUM_EVENTS-1:0]              event_valid,
    output logic [NUM_ARGS*HOST_DATA_BITS-1:0] args
);
    localparam int          W        = HOST_DATA_BITS;
    localparam int unsigned NUM_REGS = 1 + NUM_EVENTS + NUM_ARGS;

    state_t                           r_state, w_state_nxt;
    reg_sel_t                         w_sel;
    logic                             w_acc, w_wr_en, w_rd_en;
    logic                             w_ctrl_wr, w_launch_start;
    logic                             r_launch, r_finish;
    logic [W-1:0]                     w_rdata, r_rdata;
    logic [NUM_ARGS-1:0][W-1:0]       r_args;
    logic [NUM_EVENTS-1:0][W-1:0]     w_evt;
    logic [NUM_EVENTS-1:0]            w_evt_inc;

    assign w_sel = reg_index(32'(host.host_req_addr), NUM_REGS);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next state and handshake outputs: accept in IDLE, hold response in READ.
    always_comb begin
        w_state_nxt          = r_state;
        host.host_req_deq    = 1'b0;
        host.host_resp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                host.host_req_deq = host.host_req_valid;
                if (host.host_req_valid && (host.host_req_opcode == OP_RD))
                    w_state_nxt = READ;
            end
            READ: begin
                host.host_resp_valid = 1'b1;
                if (host.host_resp_ready)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_acc     = (r_state == IDLE) && host.host_req_valid;
    assign w_wr_en   = w_acc && (host.host_req_opcode == OP_WR);
    assign w_rd_en   = w_acc && (host.host_req_opcode == OP_RD);
    assign w_ctrl_wr = w_wr_en && w_sel.valid && (w_sel.idx == 16'd0);

    // Counters clear only on a real 0->1 of launch; finish suppresses the write.
    assign w_launch_start = w_ctrl_wr && host.host_req_value[CTRL_LAUNCH]
                            && !r_launch && !finish;

    // Read mux over current (pre-update) register values.
    always_comb begin
        w_rdata = '0;
        if (w_sel.valid) begin
            if (w_sel.idx == 16'd0) begin
                w_rdata[CTRL_LAUNCH] = r_launch;
                w_rdata[CTRL_FINISH] = r_finish;
                w_rdata[CTRL_BUSY]   = r_launch;
            end
            for (int k = 0; k < NUM_EVENTS; k++)
                if (w_sel.idx == 16'(k + 1))
                    w_rdata = w_evt[k];
            for (int j = 0; j < NUM_ARGS; j++)
                if (w_sel.idx == 16'(1 + NUM_EVENTS + j))
                    w_rdata = r_args[j];
        end
    end

    // Response data captured at accept and held through back-pressure.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_rdata <= '0;
        else if (w_rd_en)
            r_rdata <= w_rdata;
    end

    // CTRL launch/finish bits; finish beats any same-cycle host write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_launch <= 1'b0;
            r_finish <= 1'b0;
        end else if (finish) begin
            r_launch <= 1'b0;
            r_finish <= 1'b1;
        end else if (w_ctrl_wr) begin
            r_launch <= host.host_req_value[CTRL_LAUNCH];
            if (host.host_req_value[CTRL_FINISH])
                r_finish <= 1'b0;
        end
    end

    // Argument registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_args <= '0;
        end else begin
            for (int j = 0; j < NUM_ARGS; j++)
                if (w_wr_en && w_sel.valid && (w_sel.idx == 16'(1 + NUM_EVENTS + j)))
                    r_args[j] <= host.host_req_value;
        end
    end

    for (genvar k = 0; k < NUM_EVENTS; k++) begin : g_evt
        assign w_evt_inc[k] = event_valid[k] & r_launch;
        csr_event_counter #(.W(W)) u_cnt (
            .clock   (clock),
            .reset   (reset),
            .i_clear (w_launch_start),
            .i_inc   (w_evt_inc[k]),
            .o_count (w_evt[k])
        );
    end

    assign host.host_resp_bits = r_rdata;
    assign launch              = r_launch;
    assign args                = r_args;

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: vector table, directed corners, random vs model.
module tb_csr_file;
    localparam int AB = 8;
    localparam int W  = 32;
    localparam int NE = 2;
    localparam int NA = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    // Main instance.
    csr_file_if #(.ADDR_BITS(AB), .DATA_BITS(W)) h();
    logic            launch, finish;
    logic [NE-1:0]   event_valid;
    logic [NA*W-1:0] args;

    csr_file #(.HOST_ADDR_BITS(AB), .HOST_DATA_BITS(W),
               .NUM_EVENTS(NE), .NUM_ARGS(NA)) dut (
        .clock(clock), .reset(reset), .host(h), .launch(launch),
        .finish(finish), .event_valid(event_valid), .args(args));

    // Narrow instance for saturation.
    csr_file_if #(.ADDR_BITS(AB), .DATA_BITS(8)) hb();
    logic       launch_b, finish_b;
    logic [0:0] ev_b;
    logic [7:0] args_b;

    csr_file #(.HOST_ADDR_BITS(AB), .HOST_DATA_BITS(8),
               .NUM_EVENTS(1), .NUM_ARGS(1)) dut_b (
        .clock(clock), .reset(reset), .host(hb), .launch(launch_b),
        .finish(finish_b), .event_valid(ev_b), .args(args_b));

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    bit           m_launch, m_fin, m_reading;
    logic [W-1:0] m_evt [NE];
    logic [W-1:0] m_arg [NA];

    task automatic chk(input string name, input logic [NA*W-1:0] act,
                       input logic [NA*W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_launch = 0; m_fin = 0; m_reading = 0;
        for (int k = 0; k < NE; k++) m_evt[k] = '0;
        for (int j = 0; j < NA; j++) m_arg[j] = '0;
    endtask

    function automatic logic [W-1:0] model_read(input logic [AB-1:0] a);
        logic [W-1:0] v;
        int idx;
        v   = '0;
        idx = int'(a[AB-1:2]);
        if (a[1:0] != 2'b00) return '0;
        if (idx == 0) begin
            v[0] = m_launch; v[1] = m_fin; v[2] = m_launch;
            return v;
        end
        if (idx <= NE) return m_evt[idx-1];
        if (idx <= NE + NA) return m_arg[idx-1-NE];
        return '0;
    endfunction

    // Apply one clock's worth of the register rules to the model.
    task automatic model_step();
        bit acc, wr, aligned, was_launch;
        int idx;
        logic [W-1:0] val;
        acc        = h.host_req_valid && !m_reading;
        wr         = acc && h.host_req_opcode;
        aligned    = (h.host_req_addr[1:0] == 2'b00);
        idx        = int'(h.host_req_addr[AB-1:2]);
        val        = h.host_req_value;
        was_launch = m_launch;
        if (m_reading && h.host_resp_ready) m_reading = 0;
        if (acc && !h.host_req_opcode) m_reading = 1;
        for (int k = 0; k < NE; k++)
            if (event_valid[k] && was_launch && m_evt[k] != '1) m_evt[k] = m_evt[k] + 1;
        if (finish) begin
            m_launch = 0; m_fin = 1;
        end else if (wr && aligned && idx == 0) begin
            if (val[0] && !was_launch)
                for (int k = 0; k < NE; k++) m_evt[k] = '0;
            m_launch = val[0];
            if (val[1]) m_fin = 0;
        end
        if (wr && aligned && idx > NE && idx <= NE + NA) m_arg[idx-1-NE] = val;
    endtask

    task automatic tick();
        logic [NA*W-1:0] e;
        model_step();
        @(posedge clock); #1;
        for (int j = 0; j < NA; j++) e[j*W +: W] = m_arg[j];
        chk("launch", {127'd0, launch}, {127'd0, m_launch});
        chk("args", args, e);
    endtask

    task automatic do_write(input logic [AB-1:0] a, input logic [W-1:0] v);
        h.host_req_valid = 1; h.host_req_opcode = 1;
        h.host_req_addr = a;  h.host_req_value = v;
        #1;
        chk("wr_deq", {127'd0, h.host_req_deq}, 128'd1);
        tick();
        h.host_req_valid = 0;
    endtask

    task automatic do_read(input logic [AB-1:0] a, input int stall,
                           output logic [W-1:0] got);
        logic [W-1:0] exp;
        exp = model_read(a);
        h.host_req_valid = 1; h.host_req_opcode = 0; h.host_req_addr = a;
        h.host_resp_ready = 0;
        #1;
        chk("rd_deq", {127'd0, h.host_req_deq}, 128'd1);
        tick();
        h.host_req_valid = 0;
        for (int s = 0; s < stall; s++) begin
            chk("stall_valid", {127'd0, h.host_resp_valid}, 128'd1);
            chk("stall_bits", 128'(h.host_resp_bits), 128'(exp));
            tick();
        end
        h.host_resp_ready = 1;
        #1;
        chk("resp_valid", {127'd0, h.host_resp_valid}, 128'd1);
        chk("resp_bits", 128'(h.host_resp_bits), 128'(exp));
        got = h.host_resp_bits;
        tick();
        chk("resp_drop", {127'd0, h.host_resp_valid}, 128'd0);
    endtask

    typedef struct {
        bit           wr;
        logic [AB-1:0] addr;
        logic [W-1:0] val;
        logic [W-1:0] exp;
    } vec_t;

    initial begin
        vec_t         tbl [8];
        logic [W-1:0] got;
        int           op;
        logic [AB-1:0] ra;

        h.host_req_valid = 0; h.host_req_opcode = 0; h.host_req_addr = '0;
        h.host_req_value = '0; h.host_resp_ready = 1;
        finish = 0; event_valid = '0;
        hb.host_req_valid = 0; hb.host_req_opcode = 0; hb.host_req_addr = '0;
        hb.host_req_value = '0; hb.host_resp_ready = 1;
        finish_b = 0; ev_b = '0;
        model_reset();

        // Reset state.
        #1;
        chk("rst_launch", {127'd0, launch}, 128'd0);
        chk("rst_resp_valid", {127'd0, h.host_resp_valid}, 128'd0);
        chk("rst_resp_bits", 128'(h.host_resp_bits), 128'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1;

        // Reset readback and argument registers.
        tbl[0] = '{0, 8'h00, 32'h0,    32'h0};
        tbl[1] = '{0, 8'h04, 32'h0,    32'h0};
        tbl[2] = '{0, 8'h0C, 32'h0,    32'h0};
        tbl[3] = '{1, 8'h0C, 32'h40,   32'h0};
        tbl[4] = '{1, 8'h10, 32'h1000, 32'h0};
        tbl[5] = '{0, 8'h0C, 32'h0,    32'h40};
        tbl[6] = '{0, 8'h10, 32'h0,    32'h1000};
        tbl[7] = '{0, 8'h08, 32'h0,    32'h0};
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].val);
            else begin
                do_read(tbl[i].addr, 0, got);
                chk("tbl_read", 128'(got), 128'(tbl[i].exp));
            end
        end
        chk("arg0_out", 128'(args[31:0]), 128'h40);
        chk("arg1_out", 128'(args[63:32]), 128'h1000);

        // Launch, count, finish.
        do_write(8'h00, 32'h1);
        chk("launch_on", {127'd0, launch}, 128'd1);
        event_valid = 2'b01;
        repeat (5) tick();
        event_valid = 2'b00;
        finish = 1; tick(); finish = 0;
        chk("launch_fell", {127'd0, launch}, 128'd0);
        do_read(8'h00, 0, got); chk("ctrl_done", 128'(got), 128'h2);
        do_read(8'h04, 0, got); chk("evt0_5", 128'(got), 128'h5);

        // W1C, relaunch clear, finish overriding a CTRL write.
        do_write(8'h00, 32'h2);
        do_read(8'h00, 0, got); chk("ctrl_w1c", 128'(got), 128'h0);
        do_write(8'h00, 32'h1);
        do_read(8'h04, 0, got); chk("evt0_clr", 128'(got), 128'h0);
        do_read(8'h00, 0, got); chk("ctrl_busy", 128'(got), 128'h5);
        finish = 1; do_write(8'h00, 32'h1); finish = 0;
        do_read(8'h00, 0, got); chk("ctrl_fin_wins", 128'(got), 128'h2);

        // Back-pressure with a second request waiting.
        h.host_req_valid = 1; h.host_req_opcode = 0; h.host_req_addr = 8'h10;
        h.host_resp_ready = 0;
        tick();
        h.host_req_opcode = 1; h.host_req_addr = 8'h14; h.host_req_value = 32'h55;
        for (int s = 0; s < 4; s++) begin
            #1;
            chk("bp_valid", {127'd0, h.host_resp_valid}, 128'd1);
            chk("bp_bits", 128'(h.host_resp_bits), 128'h1000);
            chk("bp_nodeq", {127'd0, h.host_req_deq}, 128'd0);
            tick();
        end
        h.host_resp_ready = 1;
        #1 chk("bp_hs_nodeq", {127'd0, h.host_req_deq}, 128'd0);
        tick();
        chk("bp_next_deq", {127'd0, h.host_req_deq}, 128'd1);
        tick();
        h.host_req_valid = 0;
        do_read(8'h14, 0, got); chk("bp_write_taken", 128'(got), 128'h55);

        // Misaligned / unmapped / read-only.
        do_read(8'h02, 0, got); chk("misaligned", 128'(got), 128'h0);
        do_read(8'hFC, 0, got); chk("unmapped", 128'(got), 128'h0);
        do_write(8'h04, 32'h1234);
        do_read(8'h04, 0, got); chk("evt_ro", 128'(got), 128'h0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            event_valid = 2'($urandom);
            finish = ($urandom_range(0, 15) == 0);
            op = int'($urandom_range(0, 2));
            ra = 8'($urandom_range(0, 40));
            if (op == 0) do_read(ra, int'($urandom_range(0, 2)), got);
            else if (op == 1)
                do_write(ra, (ra == 8'h00) ? 32'($urandom_range(0, 3)) : $urandom);
            else tick();
        end
        finish = 0; event_valid = '0;

        // Reset in the middle of a pending response.
        do_write(8'h00, 32'h1);
        h.host_req_valid = 1; h.host_req_opcode = 0; h.host_req_addr = 8'h0C;
        h.host_resp_ready = 0;
        tick();
        h.host_req_valid = 0;
        chk("pre_rst_valid", {127'd0, h.host_resp_valid}, 128'd1);
        reset = 0;
        #1;
        chk("mid_rst_valid", {127'd0, h.host_resp_valid}, 128'd0);
        chk("mid_rst_launch", {127'd0, launch}, 128'd0);
        chk("mid_rst_bits", 128'(h.host_resp_bits), 128'd0);
        @(posedge clock); #1;
        reset = 1;
        model_reset();
        h.host_resp_ready = 1;
        do_read(8'h0C, 0, got); chk("post_rst_arg", 128'(got), 128'h0);

        // Narrow instance: counter saturates at 0xFF.
        hb.host_req_valid = 1; hb.host_req_opcode = 1;
        hb.host_req_addr = 8'h00; hb.host_req_value = 8'h01;
        @(posedge clock); #1;
        hb.host_req_valid = 0;
        chk("b_launch", {127'd0, launch_b}, 128'd1);
        ev_b = 1'b1;
        repeat (300) @(posedge clock);
        #1 ev_b = 1'b0;
        hb.host_req_valid = 1; hb.host_req_opcode = 0; hb.host_req_addr = 8'h04;
        @(posedge clock); #1;
        hb.host_req_valid = 0;
        chk("b_resp_valid", {127'd0, hb.host_resp_valid}, 128'd1);
        chk("b_evt_sat", 128'(hb.host_resp_bits), 128'hFF);
        @(posedge clock); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
